uart_rx_deserializer: RTL and testbench

//  UART receive path; the counterpart of the TX bit-counter/shifter chain. Samples the

---
 rtl/uart_rx_deserializer_if.sv | 21 ++
 rtl/uart_rx_deserializer.sv | 167 ++++++++++++++++
 tb/tb_uart_rx_deserializer.sv | 260 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_rx_deserializer_if.sv
// Core-side byte handshake of the UART receiver: the receiver drives data/valid and the
// consumer drives ready.
interface uart_rx_deserializer_if #(
  parameter int unsigned DATA_BITS = 8
) ();
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_ready;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready
  );
endinterface

// File: rtl/uart_rx_deserializer.sv
// UART receive path: synchronises rx_in, frames start/data/stop bits and hands each byte
// to the consumer on a valid/ready handshake, flagging framing errors and overruns.
module uart_rx_deserializer #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned DATA_BITS    = 8
) (
  input  logic                   rx_clk_i,
  input  logic                   reset_ni,
  input  logic                   rx_in_i,
  uart_rx_deserializer_if.master rx_if,
  output logic                   frame_err_o,
  output logic                   overrun_o,
  output logic                   busy_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
  localparam int unsigned BitW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;

  localparam logic [CntW-1:0] CntMax = CntW'(CLKS_PER_BIT - 1);
  localparam logic [CntW-1:0] CntMid = CntW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [BitW-1:0] BitMax = BitW'(DATA_BITS - 1);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StStart    = 3'd1;
  localparam logic [2:0] StData     = 3'd2;
  localparam logic [2:0] StStop     = 3'd3;
  localparam logic [2:0] StWaitIdle = 3'd4;

  logic [1:0]           sync_q;
  logic                 rx_s;
  logic [2:0]           state_q, state_d;
  logic [CntW-1:0]      clk_cnt_q, clk_cnt_d;
  logic [BitW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic [DATA_BITS-1:0] data_q, data_d;
  logic                 valid_q, valid_d;
  logic                 ferr_q, ferr_d;
  logic                 ovr_q, ovr_d;
  logic                 accept;

  // Two-flop synchroniser; resets to the idle (high) line level.
  always_ff @(posedge rx_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      sync_q <= 2'b11;
    end else begin
      sync_q <= {sync_q[0], rx_in_i};
    end
  end

  assign rx_s   = sync_q[1];
  assign accept = valid_q && rx_if.rx_ready;

  always_comb begin
    state_d   = state_q;
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    data_d    = data_q;
    valid_d   = valid_q;
    ferr_d    = 1'b0;
    ovr_d     = 1'b0;

    if (accept) begin
      valid_d = 1'b0;
    end

    case (state_q)
      StIdle: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (!rx_s) begin
          state_d = StStart;
        end
      end

      StStart: begin
        if (clk_cnt_q == CntMid) begin
          clk_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = rx_s ? StIdle : StData;
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      StData: begin
        if (clk_cnt_q == CntMax) begin
          clk_cnt_d = '0;
          // LSB arrives first, so shifting right from the MSB leaves bits in order.
          shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
          if (bit_cnt_q == BitMax) begin
            bit_cnt_d = '0;
            state_d   = StStop;
          end else begin
            bit_cnt_d = bit_cnt_q + 1'b1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      StStop: begin
        if (clk_cnt_q == CntMax) begin
          clk_cnt_d = '0;
          if (rx_s) begin
            // A handshake completing this cycle frees the output register for the new byte.
            if (!valid_q || accept) begin
              data_d  = shift_q;
              valid_d = 1'b1;
            end else begin
              ovr_d = 1'b1;
            end
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StWaitIdle;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + 1'b1;
        end
      end

      StWaitIdle: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        if (rx_s) begin
          state_d = StIdle;
        end
      end

      default: begin
        clk_cnt_d = '0;
        bit_cnt_d = '0;
        state_d   = StIdle;
      end
    endcase
  end

  always_ff @(posedge rx_clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q   <= StIdle;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      ferr_q    <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      ferr_q    <= ferr_d;
      ovr_q     <= ovr_d;
    end
  end

  assign rx_if.rx_data  = data_q;
  assign rx_if.rx_valid = valid_q;
  assign frame_err_o    = ferr_q;
  assign overrun_o      = ovr_q;
  assign busy_o         = (state_q != StIdle);

endmodule

// File: tb/tb_uart_rx_deserializer.sv
// Randomised scoreboard bench for uart_rx_deserializer: serial frames are generated here,
// a frame-level model predicts bytes/flags and their cycles, a monitor checks the outputs.
module tb_uart_rx_deserializer;

  localparam int CPB = 16;
  localparam int DB  = 8;
  // Cycles from the start edge on the line to the registered result of the frame.
  localparam int FrameLat = 3 + CPB / 2 + (DB + 1) * CPB;

  typedef struct {
    logic [7:0] d;
    int         t;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic rx_in;
  logic frame_err;
  logic overrun;
  logic busy;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  bit   hold = 1'b0;

  exp_t byte_q[$];
  int   ferr_q[$];
  int   ovr_q[$];
  exp_t mon_e;
  int   mon_t;

  uart_rx_deserializer_if #(.DATA_BITS(DB)) rx_if ();

  uart_rx_deserializer #(
    .CLKS_PER_BIT(CPB),
    .DATA_BITS   (DB)
  ) dut (
    .rx_clk_i   (clk),
    .reset_ni   (rst_n),
    .rx_in_i    (rx_in),
    .rx_if      (rx_if),
    .frame_err_o(frame_err),
    .overrun_o  (overrun),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(string name, logic [31:0] got, logic [31:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", name, got, want, cyc);
    end
  endfunction

  function automatic void flag_unexpected(string name, logic [31:0] got);
    vectors++;
    miscompares++;
    $display("FAIL %s: got %0h want nothing (cycle %0d)", name, got, cyc);
  endfunction

  // Frame-level reference: what the receiver must report for one frame started at t0.
  function automatic void model_frame(logic [7:0] d, bit stop_ok, int t0);
    exp_t e;
    if (!stop_ok) begin
      ferr_q.push_back(t0 + FrameLat);
    end else if (rx_if.rx_ready) begin
      e.d = d;
      e.t = t0 + FrameLat;
      byte_q.push_back(e);
    end else if (hold) begin
      ovr_q.push_back(t0 + FrameLat);
    end else begin
      e.d = d;
      e.t = -1;
      byte_q.push_back(e);
      hold = 1'b1;
    end
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input bit stop_ok);
    model_frame(d, stop_ok, cyc);
    rx_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < DB; i++) begin
      rx_in = d[i];
      tick(CPB);
    end
    rx_in = stop_ok;
    tick(CPB);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (rx_if.rx_valid && rx_if.rx_ready) begin
        if (byte_q.size() == 0) begin
          flag_unexpected("unexpected_byte", 32'(rx_if.rx_data));
        end else begin
          mon_e = byte_q.pop_front();
          check("byte_data", 32'(rx_if.rx_data), 32'(mon_e.d));
          if (mon_e.t >= 0) check("byte_time", cyc, mon_e.t);
        end
      end
      if (frame_err) begin
        if (ferr_q.size() == 0) begin
          flag_unexpected("unexpected_frame_err", 32'(frame_err));
        end else begin
          mon_t = ferr_q.pop_front();
          check("frame_err_time", cyc, mon_t);
        end
      end
      if (overrun) begin
        if (ovr_q.size() == 0) begin
          flag_unexpected("unexpected_overrun", 32'(overrun));
        end else begin
          mon_t = ovr_q.pop_front();
          check("overrun_time", cyc, mon_t);
        end
      end
    end
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0;
    int gap;
    bit bad;
    logic [7:0] d;

    rst_n = 1'b0;
    rx_in = 1'b1;
    rx_if.rx_ready = 1'b1;
    tick(3);
    check("rst_valid", 32'(rx_if.rx_valid), 0);
    check("rst_data", 32'(rx_if.rx_data), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_overrun", 32'(overrun), 0);
    check("rst_busy", 32'(busy), 0);
    rst_n = 1'b1;
    tick(5);

    // Single frame, consumer ready.
    send_frame(8'hA5, 1'b1);
    tick(10);

    // Four-cycle low glitch must be rejected at the mid-start sample.
    t0 = cyc;
    rx_in = 1'b0;
    tick(4);
    rx_in = 1'b1;
    check("glitch_busy_start", 32'(busy), 1);
    tick(6);
    check("glitch_busy_mid", 32'(busy), 1);
    tick(1);
    check("glitch_idle_cycle", cyc - t0, 11);
    check("glitch_busy_after", 32'(busy), 0);
    tick(20);

    // Bad stop bit followed by a long break: exactly one frame error.
    send_frame(8'h3C, 1'b0);
    tick(40 * CPB);
    check("break_busy", 32'(busy), 1);
    check("break_valid", 32'(rx_if.rx_valid), 0);
    rx_in = 1'b1;
    tick(10);
    check("break_recovered_busy", 32'(busy), 0);

    // Consumer stalled: second frame overruns, first byte is held.
    rx_if.rx_ready = 1'b0;
    send_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    rx_in = 1'b1;
    tick(10);
    check("stall_valid", 32'(rx_if.rx_valid), 1);
    check("stall_data", 32'(rx_if.rx_data), 32'h11);
    rx_if.rx_ready = 1'b1;
    hold = 1'b0;
    tick(1);
    check("drain_valid", 32'(rx_if.rx_valid), 0);
    tick(10);

    // Back-to-back extremes.
    send_frame(8'h00, 1'b1);
    send_frame(8'hFF, 1'b1);
    tick(10);

    // Reset mid-frame: nothing from 0x5A may be delivered.
    d = 8'h5A;
    rx_in = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx_in = d[i];
      tick(CPB);
    end
    rx_in = d[4];
    tick(CPB / 2);
    rst_n = 1'b0;
    rx_in = 1'b1;
    #1;
    check("midrst_valid", 32'(rx_if.rx_valid), 0);
    check("midrst_data", 32'(rx_if.rx_data), 0);
    check("midrst_busy", 32'(busy), 0);
    check("midrst_frame_err", 32'(frame_err), 0);
    check("midrst_overrun", 32'(overrun), 0);
    tick(5);
    check("midrst_busy_hold", 32'(busy), 0);
    rst_n = 1'b1;
    hold = 1'b0;
    tick(20);
    send_frame(8'h81, 1'b1);
    rx_in = 1'b1;
    tick(20);

    // Randomised traffic with occasional bad stop bits and random idle gaps.
    for (int n = 0; n < 24; n++) begin
      d   = 8'($urandom);
      bad = ($urandom_range(0, 7) == 0);
      gap = $urandom_range(0, 12);
      if (bad && gap < 6) gap = 6;
      send_frame(d, !bad);
      rx_in = 1'b1;
      tick(gap);
    end

    tick(200);
    check("final_busy", 32'(busy), 0);
    check("final_valid", 32'(rx_if.rx_valid), 0);
    while (byte_q.size() > 0) begin
      mon_e = byte_q.pop_front();
      flag_unexpected("missing_byte", 32'(mon_e.d));
    end
    while (ferr_q.size() > 0) begin
      mon_t = ferr_q.pop_front();
      flag_unexpected("missing_frame_err", mon_t);
    end
    while (ovr_q.size() > 0) begin
      mon_t = ovr_q.pop_front();
      flag_unexpected("missing_overrun", mon_t);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
